// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset vector and fetch-side encodings
// used by fetch_unit and cond_branch_control.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned INSTR_W_DEF  = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        PC_KEEP   = 3'd0,
        PC_RESET  = 3'd1,
        PC_INCR   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_REDIR  = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its next-PC source mux; exposes the mux
// result so the fetch FSM can launch a request at the new PC in the same edge.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_e           sel_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] redir_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_c_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Increment wraps naturally at the register width.
    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_RESET:  pc_d = RESET_PC;
            PC_INCR:   pc_d = pc_q + ADDR_W'(1);
            PC_BRANCH: pc_d = branch_target_i;
            PC_REDIR:  pc_d = redir_addr_i;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_next_c_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues one memory read at a time, holds
// the returned word for a stallable consumer, and handles branch redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_e       state_q, state_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0]  redir_addr_q, redir_addr_d;
    pc_sel_e            pc_sel_c;
    logic [ADDR_W-1:0]  pc_next_c;
    logic               redirect_c;

    // A redirect is live if one was recorded earlier or arrives with the ack.
    assign redirect_c = redir_pend_q || branch_taken;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .sel_i           (pc_sel_c),
        .branch_target_i (branch_target),
        .redir_addr_i    (redir_addr_q),
        .pc_o            (pc),
        .pc_next_c_o     (pc_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT:  state_d = FS_FETCH;
            FS_FETCH: if (imem_ack && !redirect_c) state_d = FS_HOLD;
            FS_HOLD:  if (branch_taken || !stall) state_d = FS_FETCH;
            default:  state_d = FS_BOOT;
        endcase
    end

    // Next values for every registered output and redirect bookkeeping.
    always_comb begin
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;
        pc_sel_c      = PC_KEEP;
        case (state_q)
            FS_BOOT: begin
                pc_sel_c    = branch_taken ? PC_BRANCH : PC_RESET;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_next_c;
            end
            FS_FETCH: begin
                if (imem_ack) begin
                    if (redirect_c) begin
                        pc_sel_c     = branch_taken ? PC_BRANCH : PC_REDIR;
                        redir_pend_d = 1'b0;
                        imem_req_d   = 1'b1;
                        imem_addr_d  = pc_next_c;
                    end else begin
                        pc_sel_c      = PC_INCR;
                        instr_d       = imem_rdata;
                        instr_pc_d    = imem_addr_q;
                        instr_valid_d = 1'b1;
                        imem_req_d    = 1'b0;
                    end
                end else if (branch_taken) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = branch_target;
                end
            end
            FS_HOLD: begin
                if (branch_taken || !stall) begin
                    pc_sel_c      = branch_taken ? PC_BRANCH : PC_KEEP;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc_next_c;
                end
            end
            default: begin
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            redir_pend_q  <= 1'b0;
            redir_addr_q  <= '0;
        end else begin
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            redir_pend_q  <= redir_pend_d;
            redir_addr_q  <= redir_addr_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a driver pushes expected deliveries into a
// scoreboard queue, a negedge monitor pops one per new instr_valid.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_v = 1'b0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_addr"},  32'(imem_addr),   32'h0);
        chk({tag, "_pc"},    32'(pc),          32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, 32'(instr),       32'h0);
        chk({tag, "_ipc"},   32'(instr_pc),    32'h0);
    endtask

    task automatic push_exp(input logic [15:0] i, input logic [15:0] ipc, input logic [15:0] p);
        exp_t e;
        e.instr = i;
        e.ipc   = ipc;
        e.pc    = p;
        sb.push_back(e);
    endtask

    // Monitor: every fresh delivery must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (instr_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got instr %h pc %h, required no delivery", instr, instr_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_instr",    32'(instr),    32'(mon_e.instr));
                    chk("sb_instr_pc", 32'(instr_pc), 32'(mon_e.ipc));
                    chk("sb_pc",       32'(pc),       32'(mon_e.pc));
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0;

        // Reset, boot, first fetch at 0 acked after two cycles
        repeat (2) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        chk("boot_req_low", 32'(imem_req), 32'd0);
        tick();
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr", 32'(imem_addr), 32'h0);
        tick();
        chk("fetch_hold_req", 32'(imem_req), 32'd1);
        chk("fetch_hold_addr", 32'(imem_addr), 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        push_exp(16'h1234, 16'h0000, 16'h0001);
        tick();
        imem_ack = 1'b0;
        stall    = 1'b1;
        chk("ack_valid", 32'(instr_valid), 32'd1);
        chk("ack_req_low", 32'(imem_req), 32'd0);
        chk("ack_pc", 32'(pc), 32'h1);

        // Stall for three cycles; a stray ack while holding is ignored
        for (int i = 0; i < 3; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = 16'hEEEE;
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'h1234);
            chk("stall_ipc", 32'(instr_pc), 32'h0);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        tick();
        chk("release_valid", 32'(instr_valid), 32'd0);
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", 32'(imem_addr), 32'h1);

        // Branch in HOLD while stalled: branch wins
        imem_ack   = 1'b1;
        imem_rdata = 16'hABCD;
        stall      = 1'b1;
        push_exp(16'hABCD, 16'h0001, 16'h0002);
        tick();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        chk("hbr_valid", 32'(instr_valid), 32'd0);
        chk("hbr_req", 32'(imem_req), 32'd1);
        chk("hbr_addr", 32'(imem_addr), 32'h40);
        chk("hbr_pc", 32'(pc), 32'h40);

        // Move to address 5, then two redirects during the fetch (latest wins)
        imem_ack   = 1'b1;
        imem_rdata = 16'h0001;
        push_exp(16'h0001, 16'h0040, 16'h0041);
        tick();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        tick();
        chk("go5_addr", 32'(imem_addr), 32'h5);
        branch_target = 16'h0070;
        tick();
        chk("pend_addr_stable", 32'(imem_addr), 32'h5);
        chk("pend_req", 32'(imem_req), 32'd1);
        branch_target = 16'h0080;
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h80);
        chk("redir_pc", 32'(pc), 32'h80);

        // Wrap from 0xFFFF to 0x0000
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        push_exp(16'h5555, 16'h0080, 16'h0081);
        tick();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        tick();
        branch_taken = 1'b0;
        chk("top_addr", 32'(imem_addr), 32'hFFFF);
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        push_exp(16'h7777, 16'hFFFF, 16'h0000);
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc", 32'(pc), 32'h0);
        tick();
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'h0);

        // Reset with a request outstanding; late ack ignored
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        imem_ack   = 1'b1;
        imem_rdata = 16'h0BAD;
        tick();
        imem_ack = 1'b0;
        chk_reset_vals("lateack");
        rst_n = 1'b1;
        tick();
        chk("reboot_req", 32'(imem_req), 32'd1);
        chk("reboot_addr", 32'(imem_addr), 32'h0);
        chk("reboot_valid", 32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h4321;
        push_exp(16'h4321, 16'h0000, 16'h0001);
        tick();
        imem_ack = 1'b0;
        tick();

        // Branch during BOOT redirects the very first fetch
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0123;
        tick();
        branch_taken = 1'b0;
        chk("bootbr_addr", 32'(imem_addr), 32'h123);
        chk("bootbr_pc", 32'(pc), 32'h123);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
